// File: rtl/sggoc_io_decoder.sv
// sggoc_io_decoder: Game Gear Z80 I/O port decoder with system registers and one-shot VDP strobes.
module sggoc_io_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_do,
  input  logic        z80_io_rd,
  input  logic        z80_io_wr,
  output logic [7:0]  io_do,
  output logic        vdp_data_rd,
  output logic        vdp_data_wr,
  output logic        vdp_control_rd,
  output logic        vdp_control_wr,
  input  logic [7:0]  vdp_data_o,
  input  logic [7:0]  vdp_status,
  input  logic [7:0]  vdp_v_counter,
  input  logic [7:0]  vdp_h_counter
);
  logic [7:0] w_a;
  logic       w_vdp, w_sys_wr;
  logic       w_dr, w_dw, w_cr, w_cw;
  logic       r_dr_q, r_dw_q, r_cr_q, r_cw_q;
  logic [7:0] r_gg [1:6];
  logic [7:0] r_mem_ctrl, r_io_ctrl;
  logic [7:0] w_sys;
  logic       w_unused;
  assign w_a      = z80_addr[7:0];
  assign w_vdp    = w_a[7:6] == 2'b10;
  assign w_sys_wr = z80_io_wr && w_a[7:6] == 2'b00 && w_a != 8'h00;
  assign w_dr     = z80_io_rd & w_vdp & ~w_a[0];
  assign w_dw     = z80_io_wr & w_vdp & ~w_a[0];
  assign w_cr     = z80_io_rd & w_vdp &  w_a[0];
  assign w_cw     = z80_io_wr & w_vdp &  w_a[0];
  // Edge-detect against last cycle so a multi-clock bus cycle strobes once.
  assign vdp_data_rd    = ~rst & w_dr & ~r_dr_q;
  assign vdp_data_wr    = ~rst & w_dw & ~r_dw_q;
  assign vdp_control_rd = ~rst & w_cr & ~r_cr_q;
  assign vdp_control_wr = ~rst & w_cw & ~r_cw_q;
  assign w_unused = &{1'b0, z80_addr[15:8], r_mem_ctrl, r_io_ctrl};
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_dr_q, r_dw_q, r_cr_q, r_cw_q} <= 4'b0000;
      r_gg[1]    <= 8'h7F;
      r_gg[2]    <= 8'hFF;
      r_gg[3]    <= 8'h00;
      r_gg[4]    <= 8'hFF;
      r_gg[5]    <= 8'h00;
      r_gg[6]    <= 8'hFF;
      r_mem_ctrl <= 8'h00;
      r_io_ctrl  <= 8'hFF;
    end else begin
      {r_dr_q, r_dw_q, r_cr_q, r_cw_q} <= {w_dr, w_dw, w_cr, w_cw};
      for (int i = 1; i <= 6; i++)
        if (w_sys_wr && w_a == 8'(i)) r_gg[i] <= z80_do;
      if (w_sys_wr && w_a > 8'h06 && !w_a[0]) r_mem_ctrl <= z80_do;
      if (w_sys_wr && w_a > 8'h06 &&  w_a[0]) r_io_ctrl  <= z80_do;
    end
  end
  always_comb begin
    w_sys = w_a == 8'h00 ? 8'hC0 : 8'hFF;
    for (int i = 1; i <= 6; i++)
      if (w_a == 8'(i)) w_sys = r_gg[i];
  end
  always_comb begin
    io_do = !z80_io_rd          ? 8'hFF :
            w_a[7:6] == 2'b00   ? w_sys :
            w_a[7:6] == 2'b01   ? (w_a[0] ? vdp_h_counter : vdp_v_counter) :
            w_a[7:6] == 2'b10   ? (w_a[0] ? vdp_status : vdp_data_o) :
                                  8'hFF;
  end
endmodule

// File: tb/tb_sggoc_io_decoder.sv
// tb_sggoc_io_decoder: randomized self-checking bench for the Game Gear I/O decoder.
module tb_sggoc_io_decoder;
  logic        clk = 0, rst = 1;
  logic [15:0] z80_addr = 0;
  logic [7:0]  z80_do = 0;
  logic        z80_io_rd = 0, z80_io_wr = 0;
  logic [7:0]  io_do;
  logic        vdp_data_rd, vdp_data_wr, vdp_control_rd, vdp_control_wr;
  logic [7:0]  vdp_data_o = 0, vdp_status = 0, vdp_v_counter = 0, vdp_h_counter = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_gg [1:6];

  sggoc_io_decoder dut (
    .clk(clk), .rst(rst), .z80_addr(z80_addr), .z80_do(z80_do),
    .z80_io_rd(z80_io_rd), .z80_io_wr(z80_io_wr), .io_do(io_do),
    .vdp_data_rd(vdp_data_rd), .vdp_data_wr(vdp_data_wr),
    .vdp_control_rd(vdp_control_rd), .vdp_control_wr(vdp_control_wr),
    .vdp_data_o(vdp_data_o), .vdp_status(vdp_status),
    .vdp_v_counter(vdp_v_counter), .vdp_h_counter(vdp_h_counter));

  always #5 clk = ~clk;

  task automatic m_reset();
    m_gg[1] = 8'h7F; m_gg[2] = 8'hFF; m_gg[3] = 8'h00;
    m_gg[4] = 8'hFF; m_gg[5] = 8'h00; m_gg[6] = 8'hFF;
  endtask

  function automatic logic [7:0] m_rd(input logic [7:0] a);
    if (a == 0) return 8'hC0;
    if (a <= 6) return m_gg[a];
    if (a < 8'h40) return 8'hFF;
    if (a < 8'h80) return a % 2 ? vdp_h_counter : vdp_v_counter;
    if (a < 8'hC0) return a % 2 ? vdp_status : vdp_data_o;
    return 8'hFF;
  endfunction

  task automatic m_wr(input logic [7:0] a, input logic [7:0] d);
    if (a >= 1 && a <= 6) m_gg[a] = d;
  endtask

  task automatic rand_vdp();
    vdp_data_o = 8'($urandom); vdp_status = 8'($urandom);
    vdp_v_counter = 8'($urandom); vdp_h_counter = 8'($urandom);
  endtask

  // Drives one bus cycle of n clocks plus one idle clock; counts strobe pulses.
  task automatic acc(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input int n, output int ndr, output int ndw, output int ncr, output int ncw,
                     output logic [7:0] q, output logic st);
    z80_addr = {8'($urandom), a}; z80_do = d; z80_io_rd = rd; z80_io_wr = wr;
    ndr = 0; ndw = 0; ncr = 0; ncw = 0; st = 1; q = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ndr += int'(vdp_data_rd); ndw += int'(vdp_data_wr);
      ncr += int'(vdp_control_rd); ncw += int'(vdp_control_wr);
      if (i == 0) q = io_do; else if (io_do !== q) st = 0;
      @(posedge clk); #1;
    end
    z80_io_rd = 0; z80_io_wr = 0;
    @(negedge clk);
    ndr += int'(vdp_data_rd); ndw += int'(vdp_data_wr);
    ncr += int'(vdp_control_rd); ncw += int'(vdp_control_wr);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; z80_addr = 16'h00BE; z80_io_rd = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (vdp_data_rd !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", vdp_data_rd); end
    @(posedge clk); #1;
    z80_io_rd = 0; rst = 0; m_reset();
    @(negedge clk);
    n_chk++;
    if (io_do !== 8'hFF) begin n_fail++; $display("FAIL idle_io_do got %h want ff", io_do); end
    for (int a = 0; a <= 6; a++) begin
      int ndr, ndw, ncr, ncw; logic [7:0] q; logic st;
      acc(1, 0, 8'(a), 0, 1, ndr, ndw, ncr, ncw, q, st);
      n_chk++;
      if (q !== m_rd(8'(a))) begin n_fail++; $display("FAIL reset_val port %h got %h want %h", a, q, m_rd(8'(a))); end
    end
  endtask

  task automatic test_gg_regs();
    int ndr, ndw, ncr, ncw; logic [7:0] q; logic st;
    acc(0, 1, 8'h03, 8'h5A, 1, ndr, ndw, ncr, ncw, q, st); m_wr(8'h03, 8'h5A);
    acc(1, 0, 8'h03, 0, 1, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'h5A) begin n_fail++; $display("FAIL wr03 got %h want 5a", q); end
    acc(0, 1, 8'h00, 8'h12, 2, ndr, ndw, ncr, ncw, q, st);
    acc(1, 0, 8'h00, 0, 1, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'hC0) begin n_fail++; $display("FAIL wr00_ro got %h want c0", q); end
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(0, 63)); d = 8'($urandom);
      acc(0, 1, a, d, $urandom_range(1, 3), ndr, ndw, ncr, ncw, q, st); m_wr(a, d);
      n_chk++;
      if (ndr + ndw + ncr + ncw != 0) begin n_fail++; $display("FAIL sys_wr_strobe port %h got %0d pulses want 0", a, ndr + ndw + ncr + ncw); end
      a = 8'($urandom_range(0, 63));
      acc(1, 0, a, 0, 1, ndr, ndw, ncr, ncw, q, st);
      n_chk++;
      if (q !== m_rd(a)) begin n_fail++; $display("FAIL sys_rd port %h got %h want %h", a, q, m_rd(a)); end
    end
  endtask

  task automatic test_vdp_strobes();
    int ndr, ndw, ncr, ncw; logic [7:0] q; logic st;
    acc(0, 1, 8'hBE, 8'h40, 4, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if ({ndr, ndw, ncr, ncw} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL wr_be counts dr=%0d dw=%0d cr=%0d cw=%0d want 0 1 0 0", ndr, ndw, ncr, ncw); end
    acc(0, 1, 8'hBF, 8'h40, 4, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if ({ndr, ndw, ncr, ncw} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin n_fail++; $display("FAIL wr_bf counts dr=%0d dw=%0d cr=%0d cw=%0d want 0 0 0 1", ndr, ndw, ncr, ncw); end
    vdp_status = 8'h80;
    acc(1, 0, 8'hBF, 0, 3, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'h80 || !st || ncr != 1 || ndr + ndw + ncw != 0) begin n_fail++; $display("FAIL rd_bf io_do=%h stable=%b cr=%0d other=%0d want 80 1 1 0", q, st, ncr, ndr + ndw + ncw); end
    vdp_data_o = 8'h3C;
    acc(1, 0, 8'hBE, 0, 2, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'h3C || ndr != 1 || ndw + ncr + ncw != 0) begin n_fail++; $display("FAIL rd_be io_do=%h dr=%0d other=%0d want 3c 1 0", q, ndr, ndw + ncr + ncw); end
    for (int k = 0; k < 30; k++) begin
      logic [7:0] a; logic rd; int n, odd;
      a = 8'($urandom_range(8'h80, 8'hBF)); rd = 1'($urandom); n = $urandom_range(1, 5); odd = a % 2;
      rand_vdp();
      acc(rd, !rd, a, 8'($urandom), n, ndr, ndw, ncr, ncw, q, st);
      n_chk++;
      if (ndr != int'(rd && !odd) || ndw != int'(!rd && !odd) || ncr != int'(rd && odd) || ncw != int'(!rd && odd))
        begin n_fail++; $display("FAIL rand_strobe port %h rd=%b n=%0d got %0d %0d %0d %0d", a, rd, n, ndr, ndw, ncr, ncw); end
      n_chk++;
      if (rd && (q !== m_rd(a) || !st)) begin n_fail++; $display("FAIL rand_vdp_rd port %h got %h want %h", a, q, m_rd(a)); end
    end
  endtask

  task automatic test_read_mux();
    int ndr, ndw, ncr, ncw; logic [7:0] q; logic st;
    vdp_v_counter = 8'hC1; vdp_h_counter = 8'h55;
    acc(1, 0, 8'h7E, 0, 1, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'hC1) begin n_fail++; $display("FAIL rd_7e got %h want c1", q); end
    acc(1, 0, 8'h7F, 0, 1, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'h55) begin n_fail++; $display("FAIL rd_7f got %h want 55", q); end
    acc(0, 1, 8'h7F, 8'h9F, 2, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (ndr + ndw + ncr + ncw != 0) begin n_fail++; $display("FAIL psg_wr got %0d pulses want 0", ndr + ndw + ncr + ncw); end
    for (int a = 1; a <= 6; a++) begin
      acc(1, 0, 8'(a), 0, 1, ndr, ndw, ncr, ncw, q, st);
      n_chk++;
      if (q !== m_gg[a]) begin n_fail++; $display("FAIL psg_no_change port %h got %h want %h", a, q, m_gg[a]); end
    end
    acc(1, 0, 8'hDC, 0, 1, ndr, ndw, ncr, ncw, q, st);
    n_chk++;
    if (q !== 8'hFF) begin n_fail++; $display("FAIL rd_dc got %h want ff", q); end
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a; a = 8'($urandom);
      rand_vdp();
      acc(1, 0, a, 0, 1, ndr, ndw, ncr, ncw, q, st);
      n_chk++;
      if (q !== m_rd(a)) begin n_fail++; $display("FAIL rand_rd port %h got %h want %h", a, q, m_rd(a)); end
    end
    z80_addr = 16'h0001;
    @(negedge clk);
    n_chk++;
    if (io_do !== 8'hFF) begin n_fail++; $display("FAIL idle_io_do2 got %h want ff", io_do); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ndr, ndw, ncr, ncw, tot; logic [7:0] q; logic st;
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      acc(1, 0, 8'hBE, 0, 2, ndr, ndw, ncr, ncw, q, st);
      tot += ndr;
    end
    n_chk++;
    if (tot != 3) begin n_fail++; $display("FAIL b2b_rd got %0d pulses want 3", tot); end
    tot = 0;
    z80_addr = 16'h00BE; z80_io_rd = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); tot += int'(vdp_data_rd);
      @(posedge clk); #1;
      z80_addr = 16'h00BC;
    end
    z80_io_rd = 0;
    @(posedge clk); #1;
    n_chk++;
    if (tot != 1) begin n_fail++; $display("FAIL addr_change got %0d pulses want 1", tot); end
  endtask

  task automatic test_reset_mid();
    int ndr, ndw, ncr, ncw, tot; logic [7:0] q; logic st;
    acc(0, 1, 8'h04, 8'hA5, 1, ndr, ndw, ncr, ncw, q, st); m_wr(8'h04, 8'hA5);
    z80_addr = 16'h00BE; z80_io_rd = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    n_chk++;
    if (vdp_data_rd !== 1'b0) begin n_fail++; $display("FAIL rst_force got %b want 0", vdp_data_rd); end
    @(posedge clk); #1;
    rst = 0; m_reset(); tot = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); tot += int'(vdp_data_rd);
      @(posedge clk); #1;
    end
    z80_io_rd = 0;
    @(posedge clk); #1;
    n_chk++;
    if (tot != 1) begin n_fail++; $display("FAIL rst_mid got %0d pulses want 1", tot); end
    for (int a = 1; a <= 6; a++) begin
      acc(1, 0, 8'(a), 0, 1, ndr, ndw, ncr, ncw, q, st);
      n_chk++;
      if (q !== m_gg[a]) begin n_fail++; $display("FAIL rst_regs port %h got %h want %h", a, q, m_gg[a]); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_gg_regs();
    test_vdp_strobes();
    test_read_mux();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
